// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Brief    : Retire-ordered store buffer with flush squash and byte forwarding
// Revision : 1.0
// ============================================================================
module store_buffer #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 26,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 20
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      alloc_valid,
   input  logic [ADDR_WIDTH-1:0]     alloc_addr,
   input  logic [DATA_WIDTH-1:0]     alloc_data,
   input  logic [DATA_WIDTH/8-1:0]   alloc_be,
   input  logic [ID_WIDTH-1:0]       alloc_id,
   output logic                      alloc_ready,
   input  logic                      retire_valid,
   input  logic [ID_WIDTH-1:0]       retire_id,
   input  logic                      flush,
   input  logic                      ld_valid,
   input  logic [ADDR_WIDTH-1:0]     ld_addr,
   input  logic [DATA_WIDTH/8-1:0]   ld_be,
   output logic                      ld_hit,
   output logic                      ld_full,
   output logic [DATA_WIDTH-1:0]     ld_data,
   output logic                      wr_valid,
   output logic [ADDR_WIDTH-1:0]     wr_addr,
   output logic [DATA_WIDTH-1:0]     wr_data,
   output logic [DATA_WIDTH/8-1:0]   wr_be,
   input  logic                      wr_ready,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      empty
);

   localparam int c_IW = $clog2(DEPTH);
   localparam int c_PW = c_IW + 1;
   localparam int c_BE = DATA_WIDTH / 8;
   localparam logic [c_PW-1:0] c_ONE = {{(c_PW-1){1'b0}}, 1'b1};

   logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
   logic [DATA_WIDTH-1:0] r_data [DEPTH];
   logic [c_BE-1:0]       r_be   [DEPTH];
   logic [ID_WIDTH-1:0]   r_id   [DEPTH];
   logic [DEPTH-1:0]      r_v;
   logic [DEPTH-1:0]      r_c;
   logic [c_PW-1:0]       r_head;
   logic [c_PW-1:0]       r_tail;
   logic [c_PW-1:0]       r_ncom;

   logic [DEPTH-1:0]      w_v_nxt;
   logic [DEPTH-1:0]      w_c_nxt;
   logic [c_PW-1:0]       w_head_nxt;
   logic [c_PW-1:0]       w_tail_nxt;
   logic [c_PW-1:0]       w_ncom_nxt;

   logic [c_PW-1:0]       w_count;
   logic [c_PW-1:0]       w_ret_ptr;
   logic [c_IW-1:0]       w_head_idx;
   logic [c_IW-1:0]       w_tail_idx;
   logic [c_IW-1:0]       w_ret_idx;
   logic [c_IW-1:0]       w_fwd_idx;
   logic                  w_retire;
   logic                  w_drain;
   logic                  w_alloc;
   logic                  w_wr_valid;
   logic [c_BE-1:0]       w_cov;
   logic [DATA_WIDTH-1:0] w_fwd_data;
   logic                  w_unused;

   assign w_count    = r_tail - r_head;
   assign w_head_idx = r_head[c_IW-1:0];
   assign w_tail_idx = r_tail[c_IW-1:0];
   assign w_ret_ptr  = r_head + r_ncom;
   assign w_ret_idx  = w_ret_ptr[c_IW-1:0];

   // count never exceeds DEPTH, so its MSB alone flags a full buffer
   assign alloc_ready = !w_count[c_IW] && !flush;
   assign w_alloc     = alloc_valid && alloc_ready;
   assign w_retire    = retire_valid && r_v[w_ret_idx] && !r_c[w_ret_idx]
                        && (r_id[w_ret_idx] == retire_id);
   assign w_wr_valid  = r_v[w_head_idx] && r_c[w_head_idx];
   assign w_drain     = w_wr_valid && wr_ready;

   // Retire, drain, flush, allocate: later steps see the earlier updates
   always_comb begin
      w_v_nxt    = r_v;
      w_c_nxt    = r_c;
      w_head_nxt = r_head;
      w_tail_nxt = r_tail;
      w_ncom_nxt = r_ncom;
      if (w_retire) begin
         w_c_nxt[w_ret_idx] = 1'b1;
         w_ncom_nxt         = w_ncom_nxt + c_ONE;
      end
      if (w_drain) begin
         w_v_nxt[w_head_idx] = 1'b0;
         w_c_nxt[w_head_idx] = 1'b0;
         w_head_nxt          = r_head + c_ONE;
         w_ncom_nxt          = w_ncom_nxt - c_ONE;
      end
      if (flush) begin
         w_v_nxt    = w_v_nxt & w_c_nxt;
         w_tail_nxt = w_head_nxt + w_ncom_nxt;
      end
      if (w_alloc) begin
         w_v_nxt[w_tail_idx] = 1'b1;
         w_c_nxt[w_tail_idx] = 1'b0;
         w_tail_nxt          = r_tail + c_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v    <= '0;
         r_c    <= '0;
         r_head <= '0;
         r_tail <= '0;
         r_ncom <= '0;
      end else begin
         r_v    <= w_v_nxt;
         r_c    <= w_c_nxt;
         r_head <= w_head_nxt;
         r_tail <= w_tail_nxt;
         r_ncom <= w_ncom_nxt;
      end
   end

   // Payload needs no reset: every read is qualified by its valid bit
   always_ff @(posedge clk) begin
      if (w_alloc) begin
         r_addr[w_tail_idx] <= alloc_addr;
         r_data[w_tail_idx] <= alloc_data;
         r_be[w_tail_idx]   <= alloc_be;
         r_id[w_tail_idx]   <= alloc_id;
      end
   end

   // Walk entries oldest to youngest so younger matches overwrite older lanes
   always_comb begin
      w_cov      = '0;
      w_fwd_data = '0;
      w_fwd_idx  = '0;
      if (ld_valid) begin
         for (int k = 0; k < DEPTH; k++) begin
            w_fwd_idx = w_head_idx + k[c_IW-1:0];
            if (r_v[w_fwd_idx] &&
                (r_addr[w_fwd_idx][ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2])) begin
               for (int b = 0; b < c_BE; b++) begin
                  if (r_be[w_fwd_idx][b] && ld_be[b]) begin
                     w_cov[b]            = 1'b1;
                     w_fwd_data[8*b +: 8] = r_data[w_fwd_idx][8*b +: 8];
                  end
               end
            end
         end
      end
   end

   assign ld_hit  = ld_valid && (|w_cov);
   assign ld_full = ld_valid && (ld_be != '0) && (w_cov == ld_be);
   assign ld_data = w_fwd_data;

   assign wr_valid = w_wr_valid;
   assign wr_addr  = w_wr_valid ? r_addr[w_head_idx] : '0;
   assign wr_data  = w_wr_valid ? r_data[w_head_idx] : '0;
   assign wr_be    = w_wr_valid ? r_be[w_head_idx]   : '0;

   assign count = w_count;
   assign empty = (w_count == '0);

   assign w_unused = ^ld_addr[1:0];

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Brief    : Directed and random checks of store_buffer against a queue model
// Revision : 1.0
// ============================================================================
module tb_store_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 26;
   localparam int DW    = 32;
   localparam int IW    = 20;
   localparam int BE    = DW / 8;

   logic          clk;
   logic          rst_n;
   logic          alloc_valid;
   logic [AW-1:0] alloc_addr;
   logic [DW-1:0] alloc_data;
   logic [BE-1:0] alloc_be;
   logic [IW-1:0] alloc_id;
   logic          alloc_ready;
   logic          retire_valid;
   logic [IW-1:0] retire_id;
   logic          flush;
   logic          ld_valid;
   logic [AW-1:0] ld_addr;
   logic [BE-1:0] ld_be;
   logic          ld_hit;
   logic          ld_full;
   logic [DW-1:0] ld_data;
   logic          wr_valid;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [BE-1:0] wr_be;
   logic          wr_ready;
   logic [2:0]    count;
   logic          empty;

   store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
      .clk(clk), .rst_n(rst_n),
      .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_data(alloc_data),
      .alloc_be(alloc_be), .alloc_id(alloc_id), .alloc_ready(alloc_ready),
      .retire_valid(retire_valid), .retire_id(retire_id), .flush(flush),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be),
      .ld_hit(ld_hit), .ld_full(ld_full), .ld_data(ld_data),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .wr_ready(wr_ready), .count(count), .empty(empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [BE-1:0] be;
      logic [IW-1:0] id;
      bit            c;
   } ent_t;

   // Program-order list of live stores; index 0 is the oldest
   ent_t q[$];
   int   errors = 0;
   int   checks = 0;

   logic          e_ready, e_empty, e_wr_valid, e_hit, e_full;
   logic [2:0]    e_count;
   logic [AW-1:0] e_wr_addr;
   logic [DW-1:0] e_wr_data, e_ld_data;
   logic [BE-1:0] e_wr_be;

   function automatic int n_committed();
      int n = 0;
      while (n < q.size() && q[n].c) n++;
      return n;
   endfunction

   task automatic idle();
      alloc_valid = 0; alloc_addr = '0; alloc_data = '0; alloc_be = '0; alloc_id = '0;
      retire_valid = 0; retire_id = '0; flush = 0;
      ld_valid = 0; ld_addr = '0; ld_be = '0; wr_ready = 0;
   endtask

   task automatic put(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [BE-1:0] b, input logic [IW-1:0] id);
      alloc_valid = 1; alloc_addr = a; alloc_data = d; alloc_be = b; alloc_id = id;
   endtask

   task automatic retire(input logic [IW-1:0] id);
      retire_valid = 1; retire_id = id;
   endtask

   // Expected outputs for the current model state and the inputs now driven
   task automatic model_outputs();
      logic [BE-1:0] cov;
      e_count    = 3'(q.size());
      e_empty    = (q.size() == 0);
      e_ready    = (q.size() < DEPTH) && !flush;
      e_wr_valid = (q.size() > 0) && q[0].c;
      e_wr_addr  = e_wr_valid ? q[0].addr : '0;
      e_wr_data  = e_wr_valid ? q[0].data : '0;
      e_wr_be    = e_wr_valid ? q[0].be   : '0;
      cov        = '0;
      e_ld_data  = '0;
      if (ld_valid) begin
         foreach (q[k]) begin
            if (q[k].addr[AW-1:2] == ld_addr[AW-1:2]) begin
               for (int b = 0; b < BE; b++) begin
                  if (q[k].be[b] && ld_be[b]) begin
                     cov[b] = 1'b1;
                     e_ld_data[8*b +: 8] = q[k].data[8*b +: 8];
                  end
               end
            end
         end
      end
      e_hit  = |cov;
      e_full = ld_valid && (ld_be != '0) && (cov == ld_be);
   endtask

   task automatic settle();
      @(negedge clk);
      model_outputs();
   endtask

   // Apply the clock edge to the model: retire, drain, flush, allocate
   task automatic advance();
      int   n;
      ent_t e;
      @(posedge clk);
      n = n_committed();
      if (retire_valid && n < q.size() && q[n].id == retire_id) q[n].c = 1;
      if (e_wr_valid && wr_ready) void'(q.pop_front());
      if (flush) while (q.size() > 0 && !q[q.size()-1].c) void'(q.pop_back());
      if (alloc_valid && e_ready) begin
         e.addr = alloc_addr; e.data = alloc_data; e.be = alloc_be; e.id = alloc_id; e.c = 0;
         q.push_back(e);
      end
      #1;
   endtask

   task automatic test_reset();
      idle();
      settle();
      checks++;
      if ({count, empty, alloc_ready, wr_valid} !== {3'd0, 1'b1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: count=%0d empty=%b ready=%b wr_valid=%b want 0 1 1 0",
                  count, empty, alloc_ready, wr_valid);
      end
      checks++;
      if ({wr_addr, wr_data, wr_be, ld_hit, ld_full, ld_data} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: wr_addr=%h wr_data=%h wr_be=%h ld=%b%b %h want all 0",
                  wr_addr, wr_data, wr_be, ld_hit, ld_full, ld_data);
      end
      advance();
      flush = 1;
      settle();
      checks++;
      if (alloc_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_flush_ready: alloc_ready=%b want 0", alloc_ready);
      end
      advance();
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 4; i++) begin
         idle();
         put(26'h10 + 26'(4*(i-1)), 32'hD000_0000 | i, 4'hF, 20'(i));
         settle();
         advance();
      end
      idle();
      put(26'h20, 32'hDEAD_BEEF, 4'hF, 20'd5);
      settle();
      checks++;
      if ({count, alloc_ready, wr_valid} !== {3'd4, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL fill_full: count=%0d ready=%b wr_valid=%b want 4 0 0",
                  count, alloc_ready, wr_valid);
      end
      advance();
      idle();
      settle();
      checks++;
      if (count !== 3'd4) begin
         errors++;
         $display("FAIL fill_dropped: count=%0d want 4", count);
      end
      advance();
   endtask

   task automatic test_retire_drain();
      logic [AW-1:0] exp_a [5] = '{26'h10, 26'h14, 26'h18, 26'h1C, 26'h30};
      idle(); wr_ready = 1; retire(1);
      settle();
      checks++;
      if (wr_valid !== 1'b0) begin
         errors++; $display("FAIL retire_latency: wr_valid=%b want 0", wr_valid);
      end
      advance();
      idle(); wr_ready = 1; retire(2);
      settle();
      checks++;
      if ({wr_valid, wr_addr} !== {1'b1, exp_a[0]}) begin
         errors++; $display("FAIL drain_first: wr_valid=%b wr_addr=%h want 1 %h", wr_valid, wr_addr, exp_a[0]);
      end
      advance();
      idle(); wr_ready = 1;
      settle();
      checks++;
      if ({wr_valid, wr_addr} !== {1'b1, exp_a[1]}) begin
         errors++; $display("FAIL drain_second: wr_valid=%b wr_addr=%h want 1 %h", wr_valid, wr_addr, exp_a[1]);
      end
      advance();
      idle();
      settle();
      checks++;
      if ({count, wr_valid} !== {3'd2, 1'b0}) begin
         errors++; $display("FAIL drain_count: count=%0d wr_valid=%b want 2 0", count, wr_valid);
      end
      advance();
      // Wrap: pointers cross the end of the array
      idle(); wr_ready = 1; retire(3); put(26'h30, 32'h5555_0005, 4'hF, 20'd5);
      settle(); advance();
      idle(); wr_ready = 1; retire(4); put(26'h34, 32'h6666_0006, 4'hC, 20'd6);
      settle();
      checks++;
      if (wr_addr !== exp_a[2]) begin
         errors++; $display("FAIL wrap_addr3: wr_addr=%h want %h", wr_addr, exp_a[2]);
      end
      advance();
      idle(); wr_ready = 1; retire(5);
      settle();
      checks++;
      if (wr_addr !== exp_a[3]) begin
         errors++; $display("FAIL wrap_addr4: wr_addr=%h want %h", wr_addr, exp_a[3]);
      end
      advance();
      idle(); wr_ready = 1; retire(6);
      settle();
      checks++;
      if ({wr_valid, wr_addr, wr_data} !== {1'b1, exp_a[4], 32'h5555_0005}) begin
         errors++; $display("FAIL wrap_entry5: wr_valid=%b wr_addr=%h wr_data=%h want 1 30 55550005",
                            wr_valid, wr_addr, wr_data);
      end
      advance();
      idle(); wr_ready = 1;
      settle();
      checks++;
      if ({wr_addr, wr_data, wr_be} !== {26'h34, 32'h6666_0006, 4'hC}) begin
         errors++; $display("FAIL wrap_entry6: wr_addr=%h wr_data=%h wr_be=%h want 34 66660006 c",
                            wr_addr, wr_data, wr_be);
      end
      advance();
      idle();
      settle();
      checks++;
      if ({count, empty} !== {3'd0, 1'b1}) begin
         errors++; $display("FAIL wrap_empty: count=%0d empty=%b want 0 1", count, empty);
      end
      advance();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         idle(); put(26'h60 + 26'(4*i), 32'hF000_0000 | i, 4'hF, 20'(10 + i));
         settle(); advance();
      end
      idle(); retire(10); flush = 1; put(26'h70, 32'h1, 4'hF, 20'd13);
      settle();
      checks++;
      if (alloc_ready !== 1'b0) begin
         errors++; $display("FAIL flush_ready: alloc_ready=%b want 0", alloc_ready);
      end
      advance();
      idle();
      settle();
      checks++;
      if ({count, wr_valid, wr_addr} !== {3'd1, 1'b1, 26'h60}) begin
         errors++; $display("FAIL flush_survivor: count=%0d wr_valid=%b wr_addr=%h want 1 1 60",
                            count, wr_valid, wr_addr);
      end
      advance();
      idle(); wr_ready = 1;
      settle(); advance();
      idle(); put(26'h74, 32'h7777_7777, 4'hF, 20'd14);
      settle();
      checks++;
      if ({count, empty, alloc_ready} !== {3'd0, 1'b1, 1'b1}) begin
         errors++; $display("FAIL flush_drained: count=%0d empty=%b ready=%b want 0 1 1",
                            count, empty, alloc_ready);
      end
      advance();
      idle(); ld_valid = 1; ld_addr = 26'h74; ld_be = 4'hF;
      settle();
      checks++;
      if ({count, ld_full, ld_data} !== {3'd1, 1'b1, 32'h7777_7777}) begin
         errors++; $display("FAIL flush_tail: count=%0d ld_full=%b ld_data=%h want 1 1 77777777",
                            count, ld_full, ld_data);
      end
      advance();
      idle(); flush = 1;
      settle(); advance();
   endtask

   task automatic test_forward();
      idle(); put(26'h20, 32'h0000_AAAA, 4'b0011, 20'd20);
      settle(); advance();
      idle(); put(26'h20, 32'h00BB_BB00, 4'b0110, 20'd21);
      ld_valid = 1; ld_addr = 26'h20; ld_be = 4'hF;
      settle();
      checks++;
      if ({ld_hit, ld_full, ld_data} !== {1'b1, 1'b0, 32'h0000_AAAA}) begin
         errors++; $display("FAIL fwd_older_only: hit=%b full=%b data=%h want 1 0 0000aaaa",
                            ld_hit, ld_full, ld_data);
      end
      advance();
      idle(); ld_valid = 1; ld_addr = 26'h20; ld_be = 4'hF;
      settle();
      checks++;
      if ({ld_hit, ld_full, ld_data} !== {1'b1, 1'b0, 32'h00BB_BBAA}) begin
         errors++; $display("FAIL fwd_merge: hit=%b full=%b data=%h want 1 0 00bbbbaa",
                            ld_hit, ld_full, ld_data);
      end
      advance();
      idle(); ld_valid = 1; ld_addr = 26'h23; ld_be = 4'b0111;
      settle();
      checks++;
      if ({ld_hit, ld_full, ld_data} !== {1'b1, 1'b1, 32'h00BB_BBAA}) begin
         errors++; $display("FAIL fwd_full: hit=%b full=%b data=%h want 1 1 00bbbbaa",
                            ld_hit, ld_full, ld_data);
      end
      advance();
      idle(); ld_valid = 1; ld_addr = 26'h24; ld_be = 4'hF;
      settle();
      checks++;
      if ({ld_hit, ld_full, ld_data} !== {1'b0, 1'b0, 32'h0}) begin
         errors++; $display("FAIL fwd_miss: hit=%b full=%b data=%h want 0 0 0", ld_hit, ld_full, ld_data);
      end
      advance();
      idle(); ld_valid = 0; ld_addr = 26'h20; ld_be = 4'hF;
      settle();
      checks++;
      if ({ld_hit, ld_full, ld_data} !== {1'b0, 1'b0, 32'h0}) begin
         errors++; $display("FAIL fwd_idle: hit=%b full=%b data=%h want 0 0 0", ld_hit, ld_full, ld_data);
      end
      advance();
      idle(); flush = 1;
      settle(); advance();
   endtask

   task automatic test_backpressure();
      idle(); put(26'h44, 32'hCAFE_0030, 4'b1010, 20'd30);
      settle(); advance();
      idle(); retire(30);
      settle(); advance();
      for (int i = 0; i < 5; i++) begin
         idle();
         if (i == 1) flush = 1;
         if (i == 2) put(26'h48, 32'h0000_0031, 4'hF, 20'd31);
         settle();
         checks++;
         if ({wr_valid, wr_addr, wr_data, wr_be} !== {1'b1, 26'h44, 32'hCAFE_0030, 4'b1010}) begin
            errors++; $display("FAIL bp_hold[%0d]: wr_valid=%b wr_addr=%h wr_data=%h wr_be=%h want 1 44 cafe0030 a",
                               i, wr_valid, wr_addr, wr_data, wr_be);
         end
         advance();
      end
      idle(); wr_ready = 1;
      settle(); advance();
      idle();
      settle();
      checks++;
      if ({count, wr_valid} !== {3'd1, 1'b0}) begin
         errors++; $display("FAIL bp_release: count=%0d wr_valid=%b want 1 0", count, wr_valid);
      end
      advance();
      idle(); flush = 1;
      settle(); advance();
   endtask

   task automatic test_async_reset();
      idle(); put(26'h50, 32'h4040_4040, 4'hF, 20'd40);
      settle(); advance();
      idle(); put(26'h54, 32'h4141_4141, 4'hF, 20'd41); retire(40);
      settle(); advance();
      idle(); put(26'h58, 32'h4242_4242, 4'hF, 20'd42); retire(41);
      settle(); advance();
      idle();
      settle();
      checks++;
      if ({count, wr_valid} !== {3'd3, 1'b1}) begin
         errors++; $display("FAIL ar_setup: count=%0d wr_valid=%b want 3 1", count, wr_valid);
      end
      wr_ready = 1; ld_valid = 1; ld_addr = 26'h50; ld_be = 4'hF;
      #2 rst_n = 0;
      #1;
      checks++;
      if ({count, empty, alloc_ready, wr_valid, ld_hit, ld_full} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL ar_state: count=%0d empty=%b ready=%b wr_valid=%b hit=%b full=%b want 0 1 1 0 0 0",
                            count, empty, alloc_ready, wr_valid, ld_hit, ld_full);
      end
      checks++;
      if ({wr_addr, wr_data, wr_be, ld_data} !== '0) begin
         errors++; $display("FAIL ar_data: wr_addr=%h wr_data=%h wr_be=%h ld_data=%h want 0",
                            wr_addr, wr_data, wr_be, ld_data);
      end
      q.delete();
      idle();
      @(posedge clk);
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         idle(); wr_ready = 1; retire(20'(40 + i));
         settle();
         checks++;
         if ({wr_valid, count} !== {1'b0, 3'd0}) begin
            errors++; $display("FAIL ar_after[%0d]: wr_valid=%b count=%0d want 0 0", i, wr_valid, count);
         end
         advance();
      end
   endtask

   task automatic test_random();
      int next_id = 100;
      int n;
      for (int cyc = 0; cyc < 400; cyc++) begin
         idle();
         alloc_valid  = ($urandom_range(0, 3) != 0);
         alloc_addr   = 26'h100 + 26'($urandom_range(0, 15));
         alloc_data   = $urandom;
         alloc_be     = 4'($urandom_range(1, 15));
         alloc_id     = 20'(next_id);
         ld_valid     = ($urandom_range(0, 3) != 0);
         ld_addr      = 26'h100 + 26'($urandom_range(0, 15));
         ld_be        = 4'($urandom_range(1, 15));
         wr_ready     = ($urandom_range(0, 2) != 0);
         flush        = ($urandom_range(0, 24) == 0);
         retire_valid = ($urandom_range(0, 1) != 0);
         n = n_committed();
         if (n < q.size() && $urandom_range(0, 3) != 0) retire_id = q[n].id;
         else retire_id = 20'($urandom_range(0, 99));
         settle();
         checks++;
         if ({count, empty, alloc_ready} !== {e_count, e_empty, e_ready}) begin
            errors++; $display("FAIL rnd_status[%0d]: count=%0d empty=%b ready=%b want %0d %b %b",
                               cyc, count, empty, alloc_ready, e_count, e_empty, e_ready);
         end
         checks++;
         if ({wr_valid, wr_addr, wr_data, wr_be} !== {e_wr_valid, e_wr_addr, e_wr_data, e_wr_be}) begin
            errors++; $display("FAIL rnd_wr[%0d]: got %b %h %h %h want %b %h %h %h", cyc,
                               wr_valid, wr_addr, wr_data, wr_be, e_wr_valid, e_wr_addr, e_wr_data, e_wr_be);
         end
         checks++;
         if ({ld_hit, ld_full, ld_data} !== {e_hit, e_full, e_ld_data}) begin
            errors++; $display("FAIL rnd_ld[%0d]: got %b %b %h want %b %b %h", cyc,
                               ld_hit, ld_full, ld_data, e_hit, e_full, e_ld_data);
         end
         if (alloc_valid && e_ready) next_id++;
         advance();
      end
   endtask

   initial begin
      idle();
      rst_n = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
      test_reset();
      test_fill();
      test_retire_drain();
      test_flush();
      test_forward();
      test_backpressure();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded 200000 time units");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
